// File: rtl/urp_dll_pkg.sv
// Shared widths, FSM state type and the LCRC generator for the TX data-link replay stage.
// CRC-32 here is MSB-first, unreflected, init all-ones and inverted on output.
package urp_dll_pkg;

  localparam int SEQ_W    = 12;
  localparam int TLP_W    = 1024;
  localparam int FRAME_W  = 1072;
  localparam int CRC_IN_W = 4 + SEQ_W + TLP_W;

  localparam logic [31:0] CRC32_POLY = 32'h04C1_1DB7;

  typedef enum logic {
    NORMAL,
    REPLAY
  } tx_dll_state_e;

  function automatic logic [31:0] lcrc32(input logic [CRC_IN_W-1:0] data);
    logic [31:0] crc;
    logic        fb;
    crc = 32'hFFFF_FFFF;
    for (int i = CRC_IN_W - 1; i >= 0; i--) begin
      fb  = crc[31] ^ data[i];
      crc = {crc[30:0], 1'b0};
      if (fb) crc = crc ^ CRC32_POLY;
    end
    return ~crc;
  endfunction

endpackage

// File: rtl/tx_replay_buf.sv
// Replay storage: one write port, one asynchronous read port, indexed by low sequence bits.
// Contents are not reset; entries are only read after being written under sequence control.
module tx_replay_buf #(
  parameter int DEPTH = 16,
  parameter int W     = 1024
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [W-1:0]             wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [W-1:0]             rd_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/tx_dll_replay.sv
// TX data-link layer: sequence-numbers and LCRC-frames TLPs, holds them until ACKed,
// replays on NAK or ACK timeout; single output register with valid/ready hold.
module tx_dll_replay
  import urp_dll_pkg::*;
#(
  parameter int REPLAY_DEPTH   = 16,
  parameter int REPLAY_TIMEOUT = 1024
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [TLP_W-1:0]              tlp_in,
  input  logic                          tlp_in_valid,
  output logic                          tlp_in_ready,
  output logic [FRAME_W-1:0]            frame_out,
  output logic                          frame_out_valid,
  input  logic                          frame_out_ready,
  input  logic                          ack_valid,
  input  logic                          ack_is_nak,
  input  logic [SEQ_W-1:0]              ack_seq,
  output logic                          replay_active,
  output logic                          replay_rollover,
  output logic                          ack_err,
  output logic [$clog2(REPLAY_DEPTH):0] buf_count
);

  localparam int IW = $clog2(REPLAY_DEPTH);
  localparam int TW = $clog2(REPLAY_TIMEOUT + 1);

  tx_dll_state_e    state_q, state_d;
  logic [SEQ_W-1:0] next_seq_q, ackd_seq_q, rptr_q, rptr_d, rptr_off;
  logic [SEQ_W-1:0] count, ack_dist;
  logic [TW-1:0]    timer_q;
  logic [1:0]       replay_num_q, rn_base;

  logic             full, load_ok, accept;
  logic             ack_ok, ack_prog, nak_ok, timeout, enter_replay;
  logic             replay_load, frame_load;
  logic [SEQ_W-1:0] load_seq;
  logic [TLP_W-1:0] load_tlp, rd_data;
  logic [31:0]      load_crc;

  tx_replay_buf #(
    .DEPTH (REPLAY_DEPTH),
    .W     (TLP_W)
  ) u_buf (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (next_seq_q[IW-1:0]),
    .wr_data (tlp_in),
    .rd_addr (rptr_q[IW-1:0]),
    .rd_data (rd_data)
  );

  always_comb begin
    count        = next_seq_q - ackd_seq_q - 12'd1;
    full         = (count == SEQ_W'(REPLAY_DEPTH));
    load_ok      = !frame_out_valid || frame_out_ready;
    tlp_in_ready = (state_q == NORMAL) && !full && load_ok;
    accept       = tlp_in_valid && tlp_in_ready;

    ack_dist     = ack_seq - ackd_seq_q;
    ack_ok       = ack_valid && (ack_dist <= count);
    ack_prog     = ack_ok && (ack_dist != '0);
    nak_ok       = ack_ok && ack_is_nak;
    // Progress in the same cycle restarts the timeout window instead of firing it.
    timeout      = (state_q == NORMAL) && (count != '0) &&
                   (timer_q == TW'(REPLAY_TIMEOUT)) && !ack_prog;
    enter_replay = nak_ok || timeout;
    rn_base      = ack_prog ? 2'd0 : replay_num_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= NORMAL;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    rptr_d      = rptr_q;
    rptr_off    = '0;
    replay_load = 1'b0;
    case (state_q)
      NORMAL: begin
        if (enter_replay) begin
          state_d = REPLAY;
          rptr_d  = nak_ok ? (ack_seq + 12'd1) : (ackd_seq_q + 12'd1);
        end
      end
      REPLAY: begin
        if (nak_ok) begin
          rptr_d = ack_seq + 12'd1;
        end else if (rptr_q == next_seq_q) begin
          state_d = NORMAL;
        end else begin
          if (load_ok) begin
            replay_load = 1'b1;
            rptr_d      = rptr_q + 12'd1;
          end
          // Skip entries an ACK just purged: compare both positions relative to old ackd.
          rptr_off = rptr_d - ackd_seq_q - 12'd1;
          if (ack_prog && (ack_dist > rptr_off)) rptr_d = ack_seq + 12'd1;
        end
      end
      default: state_d = NORMAL;
    endcase
  end

  always_comb begin
    frame_load = accept || replay_load;
    load_seq   = replay_load ? rptr_q  : next_seq_q;
    load_tlp   = replay_load ? rd_data : tlp_in;
  end

  assign load_crc      = lcrc32({4'b0000, load_seq, load_tlp});
  assign replay_active = (state_q == REPLAY);
  assign buf_count     = count[IW:0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      next_seq_q      <= '0;
      ackd_seq_q      <= 12'hFFF;
      rptr_q          <= '0;
      timer_q         <= '0;
      replay_num_q    <= '0;
      frame_out       <= '0;
      frame_out_valid <= 1'b0;
      replay_rollover <= 1'b0;
      ack_err         <= 1'b0;
    end else begin
      rptr_q <= rptr_d;
      if (accept) next_seq_q <= next_seq_q + 12'd1;
      if (ack_ok) ackd_seq_q <= ack_seq;

      if (load_ok) begin
        frame_out_valid <= frame_load;
        if (frame_load) frame_out <= {4'b0000, load_seq, load_tlp, load_crc};
      end

      ack_err         <= ack_valid && !ack_ok;
      replay_rollover <= enter_replay && (rn_base == 2'd3);

      if (enter_replay)  replay_num_q <= rn_base + 2'd1;
      else if (ack_prog) replay_num_q <= '0;

      if (state_q != NORMAL || enter_replay || ack_prog || count == '0) timer_q <= '0;
      else                                                              timer_q <= timer_q + TW'(1);
    end
  end

endmodule

// File: tb/tb_tx_dll_replay.sv
// Directed bench for tx_dll_replay: ACK/NAK vector table plus hand-written framing,
// fill, replay, timeout/rollover, stall and reset sequences against a reference LCRC.
module tb_tx_dll_replay;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1023:0] tlp_in;
  logic          tlp_in_valid;
  logic          tlp_in_ready;
  logic [1071:0] frame_out;
  logic          frame_out_valid;
  logic          frame_out_ready;
  logic          ack_valid;
  logic          ack_is_nak;
  logic [11:0]   ack_seq;
  logic          replay_active;
  logic          replay_rollover;
  logic          ack_err;
  logic [4:0]    buf_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tx_dll_replay #(
    .REPLAY_DEPTH   (16),
    .REPLAY_TIMEOUT (1024)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .tlp_in          (tlp_in),
    .tlp_in_valid    (tlp_in_valid),
    .tlp_in_ready    (tlp_in_ready),
    .frame_out       (frame_out),
    .frame_out_valid (frame_out_valid),
    .frame_out_ready (frame_out_ready),
    .ack_valid       (ack_valid),
    .ack_is_nak      (ack_is_nak),
    .ack_seq         (ack_seq),
    .replay_active   (replay_active),
    .replay_rollover (replay_rollover),
    .ack_err         (ack_err),
    .buf_count       (buf_count)
  );

  typedef struct {
    logic        nak;
    logic [11:0] seq;
    logic [4:0]  exp_cnt;
    logic        exp_err;
    logic        exp_rep;
  } ack_vec_t;

  // Reference LCRC by polynomial long division of the augmented message;
  // the all-ones preset is folded into the leading 32 message bits.
  function automatic logic [31:0] ref_lcrc(input logic [1039:0] msg);
    logic [1071:0] m;
    m = {msg, 32'h0};
    m[1071:1040] = m[1071:1040] ^ 32'hFFFF_FFFF;
    for (int i = 1071; i >= 32; i--) begin
      if (m[i]) m[i -: 33] = m[i -: 33] ^ {1'b1, 32'h04C1_1DB7};
    end
    return ~m[31:0];
  endfunction

  function automatic logic [1023:0] pat(input int k);
    logic [1023:0] t;
    for (int j = 0; j < 32; j++)
      t[j*32 +: 32] = 32'(k + 1) * 32'h9E37_79B9 + 32'(j) * 32'h0100_0193 + 32'h5A5A_0000;
    return t;
  endfunction

  function automatic logic [1071:0] exp_frame(input logic [11:0] seq, input logic [1023:0] tlp);
    logic [1039:0] m;
    m = {4'b0000, seq, tlp};
    return {m, ref_lcrc(m)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_frame(input string name, input int k);
    chk({name, "_vld"}, 64'(frame_out_valid), 64'd1);
    chk({name, "_seq"}, 64'(frame_out[1067:1056]), 64'(k % 4096));
    chk({name, "_frame"}, 64'(frame_out == exp_frame(12'(k), pat(k))), 64'd1);
  endtask

  task automatic send(input int k);
    tlp_in       = pat(k);
    tlp_in_valid = 1'b1;
    chk("send_in_ready", 64'(tlp_in_ready), 64'd1);
    step();
    tlp_in_valid = 1'b0;
    check_frame("send", k);
  endtask

  task automatic ack(input logic nak, input logic [11:0] s);
    ack_valid  = 1'b1;
    ack_is_nak = nak;
    ack_seq    = s;
    step();
    ack_valid  = 1'b0;
    ack_is_nak = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_vld"}, 64'(frame_out_valid), 64'd0);
    chk({name, "_frame_zero"}, 64'(frame_out == '0), 64'd1);
    chk({name, "_replay_active"}, 64'(replay_active), 64'd0);
    chk({name, "_rollover"}, 64'(replay_rollover), 64'd0);
    chk({name, "_ack_err"}, 64'(ack_err), 64'd0);
    chk({name, "_buf_count"}, 64'(buf_count), 64'd0);
  endtask

  initial begin
    ack_vec_t      av[7];
    logic [1071:0] saved;
    int            idx;
    int            waited;
    bit            stable;

    // Starting point: seq 0..7 outstanding, ackd_seq = FFF.
    av[0] = '{nak: 1'b0, seq: 12'd100, exp_cnt: 5'd8, exp_err: 1'b1, exp_rep: 1'b0};
    av[1] = '{nak: 1'b0, seq: 12'd1,   exp_cnt: 5'd6, exp_err: 1'b0, exp_rep: 1'b0};
    av[2] = '{nak: 1'b0, seq: 12'd1,   exp_cnt: 5'd6, exp_err: 1'b0, exp_rep: 1'b0};
    av[3] = '{nak: 1'b0, seq: 12'd0,   exp_cnt: 5'd6, exp_err: 1'b1, exp_rep: 1'b0};
    av[4] = '{nak: 1'b0, seq: 12'd7,   exp_cnt: 5'd0, exp_err: 1'b0, exp_rep: 1'b0};
    av[5] = '{nak: 1'b1, seq: 12'd7,   exp_cnt: 5'd0, exp_err: 1'b0, exp_rep: 1'b1};
    av[6] = '{nak: 1'b0, seq: 12'd8,   exp_cnt: 5'd0, exp_err: 1'b1, exp_rep: 1'b0};

    reset_n         = 1'b0;
    tlp_in          = '0;
    tlp_in_valid    = 1'b0;
    frame_out_ready = 1'b1;
    ack_valid       = 1'b0;
    ack_is_nak      = 1'b0;
    ack_seq         = '0;

    step();
    step();
    check_reset_outputs("reset");
    reset_n = 1'b1;
    chk("reset_in_ready", 64'(tlp_in_ready), 64'd1);

    // Three back-to-back TLPs, then an ACK outside the window.
    for (int k = 0; k < 3; k++) send(k);
    step();
    chk("b2b_idle_vld", 64'(frame_out_valid), 64'd0);
    ack(1'b0, 12'd100);
    chk("ack100_err", 64'(ack_err), 64'd1);
    chk("ack100_count", 64'(buf_count), 64'd3);
    step();
    chk("ack_err_pulse_end", 64'(ack_err), 64'd0);

    // ACK/NAK window table.
    do_reset();
    for (int k = 0; k < 8; k++) send(k);
    for (int i = 0; i < 7; i++) begin
      ack(av[i].nak, av[i].seq);
      chk($sformatf("vec%0d_count", i), 64'(buf_count), 64'(av[i].exp_cnt));
      chk($sformatf("vec%0d_err", i), 64'(ack_err), 64'(av[i].exp_err));
      chk($sformatf("vec%0d_replay", i), 64'(replay_active), 64'(av[i].exp_rep));
    end

    // Fill the replay buffer, then free it with an ACK.
    do_reset();
    for (int k = 0; k < 16; k++) send(k);
    tlp_in       = pat(16);
    tlp_in_valid = 1'b1;
    chk("full_in_ready", 64'(tlp_in_ready), 64'd0);
    chk("full_count", 64'(buf_count), 64'd16);
    step();
    tlp_in_valid = 1'b0;
    chk("full_no_frame", 64'(frame_out_valid), 64'd0);
    ack(1'b0, 12'd5);
    chk("full_ack_count", 64'(buf_count), 64'd10);
    chk("full_ack_ready", 64'(tlp_in_ready), 64'd1);

    // NAK-driven replay of 4..7.
    do_reset();
    for (int k = 0; k < 8; k++) send(k);
    ack(1'b1, 12'd3);
    chk("nak_replay_active", 64'(replay_active), 64'd1);
    chk("nak_count", 64'(buf_count), 64'd4);
    idx = 4;
    for (int c = 0; c < 50 && replay_active; c++) begin
      step();
      if (frame_out_valid) begin
        check_frame("nak_replay", idx);
        idx++;
      end
    end
    chk("nak_replay_last", 64'(idx), 64'd8);
    chk("nak_exit", 64'(replay_active), 64'd0);
    chk("nak_exit_count", 64'(buf_count), 64'd4);

    // Timeout replays; the fourth without ACK progress reports rollover.
    do_reset();
    for (int k = 0; k < 3; k++) send(k);
    for (int r = 1; r <= 4; r++) begin
      waited = 0;
      while (!replay_active && waited < 1100) begin
        step();
        waited++;
      end
      chk($sformatf("to%0d_enter", r), 64'(replay_active), 64'd1);
      chk($sformatf("to%0d_latency", r), 64'(waited >= 1000 && waited <= 1040), 64'd1);
      chk($sformatf("to%0d_rollover", r), 64'(replay_rollover), 64'(r == 4));
      idx = 0;
      for (int c = 0; c < 30 && replay_active; c++) begin
        step();
        if (frame_out_valid) begin
          check_frame("to_replay", idx);
          idx++;
        end
      end
      chk($sformatf("to%0d_frames", r), 64'(idx), 64'd3);
      chk($sformatf("to%0d_rollover_clear", r), 64'(replay_rollover), 64'd0);
      chk($sformatf("to%0d_count", r), 64'(buf_count), 64'd3);
    end

    // Output stall, NAK under stall, then reset in the middle of the replay.
    do_reset();
    for (int k = 0; k < 4; k++) send(k);
    step();
    frame_out_ready = 1'b0;
    send(4);
    saved  = frame_out;
    stable = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      if (frame_out != saved || !frame_out_valid) stable = 1'b0;
    end
    chk("stall_stable", 64'(stable), 64'd1);
    chk("stall_in_ready", 64'(tlp_in_ready), 64'd0);
    ack(1'b1, 12'd1);
    chk("stall_nak_replay", 64'(replay_active), 64'd1);
    chk("stall_nak_hold", 64'(frame_out == saved), 64'd1);
    frame_out_ready = 1'b1;
    step();
    check_frame("stall_replay", 2);
    reset_n = 1'b0;
    step();
    check_reset_outputs("mid_replay_reset");
    reset_n = 1'b1;
    send(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
